// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, registers one fetched instruction toward
// decode with a valid/ready handshake, and streams new programs into imem in LOAD.
module instr_fetch #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 256,
  parameter int RESET_PC  = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              imem_write,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic              load_done,
  output logic [ADDR_W-1:0] load_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [ADDR_W-1:0] DEPTH     = ADDR_W'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] RST_PC    = ADDR_W'(RESET_PC);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_LOAD = 1'b1
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] load_addr_q;
  logic [ADDR_W-1:0] load_count_q;
  logic [ADDR_W-1:0] out_pc_q;
  logic [DATA_W-1:0] out_instr_q;
  logic              out_valid_q;

  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] load_addr_d;
  logic              load_last_d;

  // Wrap explicitly at MEM_DEPTH-1 so non-power-of-two depths also work.
  assign pc_d        = (pc_q == LAST_ADDR) ? '0 : pc_q + ADDR_W'(1);
  assign load_addr_d = (load_addr_q == LAST_ADDR) ? '0 : load_addr_q + ADDR_W'(1);
  assign load_last_d = load_valid && (load_addr_q == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_RUN;
      pc_q         <= RST_PC;
      load_addr_q  <= '0;
      load_count_q <= '0;
      out_pc_q     <= '0;
      out_instr_q  <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (load_start) begin
            state_q      <= S_LOAD;
            out_valid_q  <= 1'b0;
            load_addr_q  <= '0;
            load_count_q <= '0;
          end else if (redirect_valid) begin
            pc_q        <= redirect_pc % DEPTH;
            out_valid_q <= 1'b0;
          end else if (!out_valid_q || out_ready) begin
            out_instr_q <= imem_rdata;
            out_pc_q    <= pc_q;
            out_valid_q <= 1'b1;
            pc_q        <= pc_d;
          end
        end
        S_LOAD: begin
          if (load_valid) begin
            load_addr_q <= load_addr_d;
            if (load_count_q != DEPTH) load_count_q <= load_count_q + ADDR_W'(1);
          end
          // A write landing on the last word ends the load just like load_done.
          if (load_done || load_last_d) begin
            state_q <= S_RUN;
            pc_q    <= RST_PC;
          end
        end
      endcase
    end
  end

  assign imem_addr  = (state_q == S_LOAD) ? load_addr_q : pc_q;
  assign imem_write = (state_q == S_LOAD) && load_valid && !reset;
  assign imem_wdata = (state_q == S_LOAD) ? load_data : '0;
  assign load_ready = (state_q == S_LOAD);
  assign load_count = load_count_q;
  assign out_valid  = out_valid_q;
  assign out_instr  = out_instr_q;
  assign out_pc     = out_pc_q;

endmodule
